// File: rtl/c_hazard_pkg.sv
// ---------------------------------------------------------------------------
// c_hazard_pkg
// Shared types and constants for the pipeline hazard unit.
//   hazard_state_t : sequencing state of the hazard FSM
//   FWD_*          : operand-select encodings driven on FwdAE / FwdBE
//   REG_ZERO       : architectural x0, never a real dependency
// ---------------------------------------------------------------------------
package c_hazard_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LU_WAIT = 2'd1,
    REDIR   = 2'd2
  } hazard_state_t;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_W_ALU = 2'b01;
  localparam logic [1:0] FWD_W_LD  = 2'b10;

  localparam logic [4:0] REG_ZERO  = 5'd0;

endpackage

// File: rtl/c_forward_unit.sv
// ---------------------------------------------------------------------------
// c_forward_unit
// Combinational W->E operand forward select for one source operand.
// Ports:
//   rs_E      in  5  source register of the instruction in E
//   rd_W      in  5  destination of the instruction in W
//   RegWE_E_W in  1  W instruction writes an ALU result
//   RegWE_W_W in  1  W instruction writes load data
//   fwd       out 2  FWD_RF / FWD_W_ALU / FWD_W_LD
// ---------------------------------------------------------------------------
module c_forward_unit
  import c_hazard_pkg::*;
(
  input  logic [4:0] rs_E,
  input  logic [4:0] rd_W,
  input  logic       RegWE_E_W,
  input  logic       RegWE_W_W,
  output logic [1:0] fwd
);

  // A match against x0 is never forwarded. When W carries both flags the
  // load data path takes precedence over the ALU result.
  always_comb begin
    fwd = FWD_RF;
    if (rd_W != REG_ZERO && rd_W == rs_E) begin
      if (RegWE_W_W) begin
        fwd = FWD_W_LD;
      end else if (RegWE_E_W) begin
        fwd = FWD_W_ALU;
      end
    end
  end

endmodule

// File: rtl/c_hazard_controller.sv
// ---------------------------------------------------------------------------
// c_hazard_controller
// Central hazard unit for the in-order F/D/E/W pipeline.
// Ports:
//   clk, reset                     clock, async active-high reset
//   rs1_D, rs2_D, rs*_used_D       sources of the instruction in D
//   rs1_E, rs2_E, rd_E, RegWE_W_E  operands / load flag of the E instruction
//   branch_taken_E, jump_E         control transfer resolved in E
//   rd_W, RegWE_E_W, RegWE_W_W     writeback of the W instruction
//   mem_access_W, dmem_ready       data memory handshake in W
//   StallF/D/E/W, FlushD/E         stage register controls
//   FwdAE, FwdBE                   operand forward selects
//   stall_count                    cycles with any stall asserted (wraps)
// ---------------------------------------------------------------------------
module c_hazard_controller
  import c_hazard_pkg::*;
#(
  parameter int LOAD_USE_BUBBLES = 1,
  parameter int FETCH_LATENCY    = 1,
  parameter int CNT_W            = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs1_D,
  input  logic [4:0]       rs2_D,
  input  logic             rs1_used_D,
  input  logic             rs2_used_D,
  input  logic [4:0]       rs1_E,
  input  logic [4:0]       rs2_E,
  input  logic [4:0]       rd_E,
  input  logic             RegWE_W_E,
  input  logic             branch_taken_E,
  input  logic             jump_E,
  input  logic [4:0]       rd_W,
  input  logic             RegWE_E_W,
  input  logic             RegWE_W_W,
  input  logic             mem_access_W,
  input  logic             dmem_ready,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallW,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       FwdAE,
  output logic [1:0]       FwdBE,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [1:0] LU_INIT  = 2'(LOAD_USE_BUBBLES - 1);
  localparam logic [1:0] RED_INIT = 2'(FETCH_LATENCY - 1);

  hazard_state_t state, state_next;
  logic [1:0]    cnt, cnt_next;
  logic          mem_wait, redirect, load_use;
  logic          stall_f, stall_d, stall_e, stall_w, flush_d, flush_e;
  logic [1:0]    fwd_a, fwd_b;

  assign mem_wait = mem_access_W && !dmem_ready;
  assign redirect = branch_taken_E || jump_E;
  assign load_use = RegWE_W_E && (rd_E != REG_ZERO) &&
                    ((rs1_used_D && rs1_D == rd_E) ||
                     (rs2_used_D && rs2_D == rd_E));

  // State and bubble counter. Reset discards any pending bubbles or flushes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      cnt   <= 2'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next state and stage controls. A memory wait freezes the whole pipe and
  // the FSM, so a branch sitting in E is simply re-evaluated once memory is
  // ready. A redirect beats a load-use match because D is then wrong-path.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    stall_f    = 1'b0;
    stall_d    = 1'b0;
    stall_e    = 1'b0;
    stall_w    = 1'b0;
    flush_d    = 1'b0;
    flush_e    = 1'b0;
    if (reset) begin
      state_next = RUN;
    end else if (mem_wait) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_w = 1'b1;
    end else begin
      unique case (state)
        RUN: begin
          if (redirect) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
            if (FETCH_LATENCY > 1) begin
              state_next = REDIR;
              cnt_next   = RED_INIT;
            end
          end else if (load_use) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
            if (LOAD_USE_BUBBLES > 1) begin
              state_next = LU_WAIT;
              cnt_next   = LU_INIT;
            end
          end
        end
        LU_WAIT: begin
          stall_f  = 1'b1;
          stall_d  = 1'b1;
          flush_e  = 1'b1;
          cnt_next = cnt - 2'd1;
          if (cnt == 2'd1) begin
            state_next = RUN;
          end
        end
        REDIR: begin
          flush_d  = 1'b1;
          cnt_next = cnt - 2'd1;
          if (cnt == 2'd1) begin
            state_next = RUN;
          end
        end
        default: begin
          state_next = RUN;
          cnt_next   = 2'd0;
        end
      endcase
    end
  end

  // A stage that is flushed must not also hold; the flush wins.
  assign StallF = stall_f;
  assign StallD = stall_d && !flush_d;
  assign StallE = stall_e && !flush_e;
  assign StallW = stall_w;
  assign FlushD = flush_d;
  assign FlushE = flush_e;

  // Count every cycle in which any stage is held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
    end else if (StallF || StallD || StallE || StallW) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

  c_forward_unit u_fwd_a (
    .rs_E      (rs1_E),
    .rd_W      (rd_W),
    .RegWE_E_W (RegWE_E_W),
    .RegWE_W_W (RegWE_W_W),
    .fwd       (fwd_a)
  );

  c_forward_unit u_fwd_b (
    .rs_E      (rs2_E),
    .rd_W      (rd_W),
    .RegWE_E_W (RegWE_E_W),
    .RegWE_W_W (RegWE_W_W),
    .fwd       (fwd_b)
  );

  assign FwdAE = reset ? FWD_RF : fwd_a;
  assign FwdBE = reset ? FWD_RF : fwd_b;

  // E holds a bubble while bubbles or wrong-path fetches are pending, so a
  // control transfer resolving there indicates a broken pipeline upstream.
  redirect_only_in_run : assert property (
    @(posedge clk) disable iff (reset)
    (!mem_wait && state != RUN) |-> !redirect
  );

endmodule

// File: tb/tb_c_hazard_controller.sv
// ---------------------------------------------------------------------------
// tb_c_hazard_controller
// Directed literal checks followed by randomized stimulus compared against a
// pending-bubble model of the hazard rules.
// ---------------------------------------------------------------------------
module tb_c_hazard_controller;

  localparam int LUB = 2;
  localparam int FL  = 2;
  localparam int CW  = 8;
  localparam int RND_CYCLES = 1500;

  typedef struct {
    logic [4:0] rs1_D, rs2_D;
    logic       rs1_used_D, rs2_used_D;
    logic [4:0] rs1_E, rs2_E, rd_E;
    logic       RegWE_W_E, branch_taken_E, jump_E;
    logic [4:0] rd_W;
    logic       RegWE_E_W, RegWE_W_W, mem_access_W, dmem_ready;
  } stim_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_W;
  logic          rs1_used_D, rs2_used_D, RegWE_W_E, branch_taken_E, jump_E;
  logic          RegWE_E_W, RegWE_W_W, mem_access_W, dmem_ready;
  logic          StallF, StallD, StallE, StallW, FlushD, FlushE;
  logic [1:0]    FwdAE, FwdBE;
  logic [CW-1:0] stall_count;
  logic [5:0]    dut_ctrl;

  int checks = 0;
  int passes = 0;

  logic       check_en = 1'b0;
  logic [5:0] exp_ctrl;
  logic [1:0] exp_fa, exp_fb;
  int         model_count;
  int         pend_lu, pend_redir;

  assign dut_ctrl = {StallF, StallD, StallE, StallW, FlushD, FlushE};

  always #5 clk = ~clk;

  c_hazard_controller #(
    .LOAD_USE_BUBBLES (LUB),
    .FETCH_LATENCY    (FL),
    .CNT_W            (CW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .rs1_D          (rs1_D),
    .rs2_D          (rs2_D),
    .rs1_used_D     (rs1_used_D),
    .rs2_used_D     (rs2_used_D),
    .rs1_E          (rs1_E),
    .rs2_E          (rs2_E),
    .rd_E           (rd_E),
    .RegWE_W_E      (RegWE_W_E),
    .branch_taken_E (branch_taken_E),
    .jump_E         (jump_E),
    .rd_W           (rd_W),
    .RegWE_E_W      (RegWE_E_W),
    .RegWE_W_W      (RegWE_W_W),
    .mem_access_W   (mem_access_W),
    .dmem_ready     (dmem_ready),
    .StallF         (StallF),
    .StallD         (StallD),
    .StallE         (StallE),
    .StallW         (StallW),
    .FlushD         (FlushD),
    .FlushE         (FlushE),
    .FwdAE          (FwdAE),
    .FwdBE          (FwdBE),
    .stall_count    (stall_count)
  );

  function automatic stim_t zeroStim();
    stim_t s;
    s.rs1_D = 0; s.rs2_D = 0; s.rs1_used_D = 0; s.rs2_used_D = 0;
    s.rs1_E = 0; s.rs2_E = 0; s.rd_E = 0; s.RegWE_W_E = 0;
    s.branch_taken_E = 0; s.jump_E = 0; s.rd_W = 0;
    s.RegWE_E_W = 0; s.RegWE_W_W = 0; s.mem_access_W = 0; s.dmem_ready = 1;
    return s;
  endfunction

  task automatic applyStimulus(input stim_t s);
    rs1_D = s.rs1_D; rs2_D = s.rs2_D;
    rs1_used_D = s.rs1_used_D; rs2_used_D = s.rs2_used_D;
    rs1_E = s.rs1_E; rs2_E = s.rs2_E; rd_E = s.rd_E;
    RegWE_W_E = s.RegWE_W_E; branch_taken_E = s.branch_taken_E;
    jump_E = s.jump_E; rd_W = s.rd_W;
    RegWE_E_W = s.RegWE_E_W; RegWE_W_W = s.RegWE_W_W;
    mem_access_W = s.mem_access_W; dmem_ready = s.dmem_ready;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle, check literal expectations mid-cycle, advance.
  task automatic stepCheck(input string name, input stim_t s, input logic [5:0] ctrl,
                           input logic [1:0] fa, input logic [1:0] fb, input int cnt);
    applyStimulus(s);
    @(negedge clk);
    checkOutput({name, "_ctrl"}, int'(dut_ctrl), int'(ctrl));
    checkOutput({name, "_fwdA"}, int'(FwdAE), int'(fa));
    checkOutput({name, "_fwdB"}, int'(FwdBE), int'(fb));
    checkOutput({name, "_cnt"}, int'(stall_count), cnt);
    tick();
  endtask

  // Hazard rules as the pipeline sees them: pending wrong-path fetches and
  // pending load-use bubbles are drained one per un-stalled cycle.
  task automatic modelOutputs(input stim_t s);
    logic mwait, redir, lu;
    mwait = s.mem_access_W && !s.dmem_ready;
    redir = s.branch_taken_E || s.jump_E;
    lu = s.RegWE_W_E && s.rd_E != 0 &&
         ((s.rs1_used_D && s.rs1_D == s.rd_E) || (s.rs2_used_D && s.rs2_D == s.rd_E));
    if (mwait)               exp_ctrl = 6'b111100;
    else if (pend_redir > 0) exp_ctrl = 6'b000010;
    else if (pend_lu > 0)    exp_ctrl = 6'b110001;
    else if (redir)          exp_ctrl = 6'b000011;
    else if (lu)             exp_ctrl = 6'b110001;
    else                     exp_ctrl = 6'b000000;
    exp_fa = 2'd0;
    exp_fb = 2'd0;
    if (s.rd_W != 0 && s.rd_W == s.rs1_E) exp_fa = s.RegWE_W_W ? 2'd2 : (s.RegWE_E_W ? 2'd1 : 2'd0);
    if (s.rd_W != 0 && s.rd_W == s.rs2_E) exp_fb = s.RegWE_W_W ? 2'd2 : (s.RegWE_E_W ? 2'd1 : 2'd0);
  endtask

  task automatic modelAdvance(input stim_t s);
    logic lu;
    lu = s.RegWE_W_E && s.rd_E != 0 &&
         ((s.rs1_used_D && s.rs1_D == s.rd_E) || (s.rs2_used_D && s.rs2_D == s.rd_E));
    if (exp_ctrl[5:2] != 4'b0) model_count = (model_count + 1) % (1 << CW);
    if (!(s.mem_access_W && !s.dmem_ready)) begin
      if (pend_redir > 0)                       pend_redir--;
      else if (pend_lu > 0)                     pend_lu--;
      else if (s.branch_taken_E || s.jump_E)    pend_redir = FL - 1;
      else if (lu)                              pend_lu = LUB - 1;
    end
  endtask

  // Compare process for the randomized phase.
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("rnd_ctrl", int'(dut_ctrl), int'(exp_ctrl));
      checkOutput("rnd_fwdA", int'(FwdAE), int'(exp_fa));
      checkOutput("rnd_fwdB", int'(FwdBE), int'(exp_fb));
      checkOutput("rnd_cnt", int'(stall_count), model_count);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    stim_t z, lu5, s;
    z = zeroStim();
    lu5 = z;
    lu5.RegWE_W_E = 1; lu5.rd_E = 5; lu5.rs1_D = 5; lu5.rs1_used_D = 1;

    // Reset with every hazard input active: outputs must stay quiet.
    reset = 1'b1;
    s = lu5;
    s.mem_access_W = 1; s.dmem_ready = 0; s.branch_taken_E = 1;
    s.RegWE_W_W = 1; s.rd_W = 7; s.rs1_E = 7; s.rs2_E = 7;
    applyStimulus(s);
    @(negedge clk);
    checkOutput("reset_ctrl", int'(dut_ctrl), 0);
    checkOutput("reset_fwdA", int'(FwdAE), 0);
    checkOutput("reset_fwdB", int'(FwdBE), 0);
    checkOutput("reset_cnt", int'(stall_count), 0);
    tick();
    applyStimulus(z);
    tick();
    reset = 1'b0;

    // Load-use with two bubbles.
    stepCheck("lu_c0", lu5, 6'b110001, 0, 0, 0);
    stepCheck("lu_c1", z,   6'b110001, 0, 0, 1);
    stepCheck("lu_c2", z,   6'b000000, 0, 0, 2);

    // Redirect beats a simultaneous load-use, then one more wrong-path flush.
    s = lu5; s.branch_taken_E = 1;
    stepCheck("br_c0", s, 6'b000011, 0, 0, 2);
    stepCheck("br_c1", z, 6'b000010, 0, 0, 2);
    stepCheck("br_c2", z, 6'b000000, 0, 0, 2);

    // Memory wait holds a pending branch for three cycles.
    s = z; s.mem_access_W = 1; s.dmem_ready = 0; s.branch_taken_E = 1;
    for (int i = 0; i < 3; i++) stepCheck("mw_stall", s, 6'b111100, 0, 0, 2 + i);
    s.dmem_ready = 1;
    stepCheck("mw_ready", s, 6'b000011, 0, 0, 5);
    stepCheck("mw_redir", z, 6'b000010, 0, 0, 5);
    stepCheck("mw_idle",  z, 6'b000000, 0, 0, 5);

    // Forwarding selects.
    s = z; s.rd_W = 7; s.RegWE_W_W = 1; s.rs1_E = 7; s.rs2_E = 7;
    stepCheck("fw_ld", s, 6'b000000, 2, 2, 5);
    s.rd_W = 0;
    stepCheck("fw_x0", s, 6'b000000, 0, 0, 5);
    s.rd_W = 7; s.RegWE_W_W = 0; s.RegWE_E_W = 1;
    stepCheck("fw_alu", s, 6'b000000, 1, 1, 5);
    s.RegWE_W_W = 1;
    stepCheck("fw_both", s, 6'b000000, 2, 2, 5);
    s.rs2_E = 3;
    stepCheck("fw_split", s, 6'b000000, 2, 0, 5);
    s.rs2_E = 7; s.mem_access_W = 1; s.dmem_ready = 0;
    stepCheck("fw_stall", s, 6'b111100, 2, 2, 5);

    // Non-matches and the rs2 path.
    s = lu5; s.rd_E = 0; s.rs1_D = 0;
    stepCheck("lu_x0", s, 6'b000000, 0, 0, 6);
    s = lu5; s.rs1_used_D = 0;
    stepCheck("lu_unused", s, 6'b000000, 0, 0, 6);
    s.rs2_D = 5; s.rs2_used_D = 1;
    stepCheck("lu_rs2_c0", s, 6'b110001, 0, 0, 6);
    stepCheck("lu_rs2_c1", z, 6'b110001, 0, 0, 7);
    stepCheck("lu_rs2_c2", z, 6'b000000, 0, 0, 8);

    // Reset while the second load-use bubble is pending.
    applyStimulus(lu5);
    @(negedge clk);
    checkOutput("rst_lu_c0", int'(dut_ctrl), 6'b110001);
    tick();
    applyStimulus(z);
    @(negedge clk);
    checkOutput("rst_lu_wait", int'(dut_ctrl), 6'b110001);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rst_async_ctrl", int'(dut_ctrl), 0);
    checkOutput("rst_async_cnt", int'(stall_count), 0);
    tick();
    tick();
    reset = 1'b0;
    stepCheck("rst_run",  z,   6'b000000, 0, 0, 0);
    stepCheck("rst_lu0",  lu5, 6'b110001, 0, 0, 0);
    stepCheck("rst_lu1",  z,   6'b110001, 0, 0, 1);
    stepCheck("rst_lu2",  z,   6'b000000, 0, 0, 2);

    // Randomized phase from a clean reset.
    reset = 1'b1;
    applyStimulus(z);
    tick();
    reset = 1'b0;
    pend_lu = 0;
    pend_redir = 0;
    model_count = 0;
    for (int c = 0; c < RND_CYCLES; c++) begin
      s.rs1_D = 5'($urandom_range(0, 3));
      s.rs2_D = 5'($urandom_range(0, 3));
      s.rs1_used_D = 1'($urandom_range(0, 1));
      s.rs2_used_D = 1'($urandom_range(0, 1));
      s.rs1_E = 5'($urandom_range(0, 3));
      s.rs2_E = 5'($urandom_range(0, 3));
      s.rd_E = 5'($urandom_range(0, 3));
      s.RegWE_W_E = 1'($urandom_range(0, 1));
      s.rd_W = 5'($urandom_range(0, 3));
      s.RegWE_E_W = 1'($urandom_range(0, 1));
      s.RegWE_W_W = 1'($urandom_range(0, 1));
      s.mem_access_W = ($urandom_range(0, 99) < 40);
      s.dmem_ready = 1'($urandom_range(0, 1));
      if (pend_lu == 0 && pend_redir == 0) begin
        s.branch_taken_E = ($urandom_range(0, 99) < 15);
        s.jump_E = ($urandom_range(0, 99) < 8);
      end else begin
        s.branch_taken_E = 1'b0;
        s.jump_E = 1'b0;
      end
      applyStimulus(s);
      modelOutputs(s);
      check_en = 1'b1;
      @(posedge clk);
      modelAdvance(s);
      #1;
    end
    check_en = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
